// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues 1-cycle-latency imem reads and
// buffers PC-tagged instructions in a 2-entry FIFO toward decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] tag_pc;
  logic        inflight;
  logic        started;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop, accept, push;

  assign pop       = fetch_valid & fetch_ready;
  assign accept    = imem_req_valid & imem_req_ready;
  // With 1-cycle latency a stale response always lands in the redirect cycle
  // itself, so the flush drops it directly and no kill flag has to outlive it.
  assign push      = inflight & ~redirect_valid;
  assign occupancy = 3'(count) + 3'(inflight);

  assign imem_addr         = pc;
  assign fetch_valid       = (count != 2'd0);
  assign fetch_instruction = fifo_instr[rd_ptr];
  assign fetch_pc          = fifo_pc[rd_ptr];
  assign halted            = (state == HALTED);

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    if (started && state == RUN && !halt && !redirect_valid &&
        (occupancy - 3'(pop)) < 3'd2)
      imem_req_valid = 1'b1;
    case (state)
      RUN:     if (halt && !inflight) state_next = HALTED;
      HALTED:  if (!halt) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      started  <= 1'b0;
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      started  <= 1'b1;
      inflight <= accept;
      if (redirect_valid)
        pc <= redirect_pc & ~32'h3;
      else if (accept)
        pc <= pc + 32'd4;
      if (accept)
        tag_pc <= pc;
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= tag_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  overflow_check: assert property (@(posedge system_clock) disable iff (!reset)
    !(push && !pop && count == 2'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle expected request/FIFO-head
// values worked out by hand against a simple 1-cycle-latency memory.
module tb_fetch_sequencer;

  logic        system_clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .system_clock      (system_clock),
    .reset             (reset),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .halt              (halt),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .halted            (halted)
  );

  always #5 system_clock = ~system_clock;

  // Memory: mem[addr>>2] = addr + 0x100, data returned the cycle after accept.
  always @(posedge system_clock)
    if (imem_req_valid && imem_req_ready)
      imem_rdata <= imem_addr + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, ".instr"}, fetch_instruction, 32'd0);
    chk({tag, ".fpc"}, fetch_pc, 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  // Drive one cycle's inputs at the falling edge, then check that cycle.
  task automatic step(input logic mr, input logic fr, input logic h,
                      input logic rd, input logic [31:0] rpc, input string tag,
                      input logic e_rv, input logic [31:0] e_addr,
                      input logic e_fv, input logic [31:0] e_pc,
                      input logic [31:0] e_ins, input logic e_h);
    @(negedge system_clock);
    imem_req_ready = mr;
    fetch_ready    = fr;
    halt           = h;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(e_rv));
    chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
    chk({tag, ".halted"}, 32'(halted), 32'(e_h));
    if (e_fv) begin
      chk({tag, ".fpc"}, fetch_pc, e_pc);
      chk({tag, ".instr"}, fetch_instruction, e_ins);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge system_clock);
    reset = 1'b0;
    #1;
    chk_reset_outputs({tag, ".in_reset"});
    repeat (2) @(negedge system_clock);
    reset = 1'b1;
    #1;
    chk({tag, ".post_release_req"}, 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    fetch_ready    = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rdata     = '0;
    #1;
    chk_reset_outputs("t0_reset");

    // 1: streaming from RESET_PC
    do_reset("t1");
    step(1, 1, 0, 0, 0, "t1_c1", 1, 32'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t1_c2", 1, 32'h4, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t1_c3", 1, 32'h8, 1, 32'h0, 32'h100, 0);
    step(1, 1, 0, 0, 0, "t1_c4", 1, 32'hC, 1, 32'h4, 32'h104, 0);
    step(1, 1, 0, 0, 0, "t1_c5", 1, 32'h10, 1, 32'h8, 32'h108, 0);

    // 2: backpressure fills the FIFO with exactly two requests
    fetch_ready = 1'b0;
    do_reset("t2");
    step(1, 0, 0, 0, 0, "t2_c1", 1, 32'h0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, "t2_c2", 1, 32'h4, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, "t2_c3", 0, 32'h8, 1, 32'h0, 32'h100, 0);
    step(1, 0, 0, 0, 0, "t2_c4", 0, 32'h8, 1, 32'h0, 32'h100, 0);
    step(1, 1, 0, 0, 0, "t2_c5", 1, 32'h8, 1, 32'h0, 32'h100, 0);
    step(1, 1, 0, 0, 0, "t2_c6", 1, 32'hC, 1, 32'h4, 32'h104, 0);
    step(1, 1, 0, 0, 0, "t2_c7", 1, 32'h10, 1, 32'h8, 32'h108, 0);

    // 3: redirect with one read in flight and one FIFO entry
    step(1, 1, 0, 1, 32'h43, "t3_c8", 0, 32'h14, 1, 32'hC, 32'h10C, 0);
    step(1, 1, 0, 0, 0, "t3_c9", 1, 32'h40, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t3_c10", 1, 32'h44, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t3_c11", 1, 32'h48, 1, 32'h40, 32'h140, 0);

    // 4: halt drains in-flight read, redirect while halted, resume
    step(1, 1, 1, 0, 0, "t4_c12", 0, 32'h4C, 1, 32'h44, 32'h144, 0);
    step(1, 1, 1, 0, 0, "t4_c13", 0, 32'h4C, 1, 32'h48, 32'h148, 0);
    step(1, 1, 1, 1, 32'h200, "t4_c14", 0, 32'h4C, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, "t4_c15", 0, 32'h200, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, "t4_c16", 0, 32'h200, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, "t4_c17", 1, 32'h200, 0, 0, 0, 0);

    // 5: memory stall at pc 0x10
    step(1, 1, 0, 1, 32'h10, "t5_c18", 0, 32'h204, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, "t5_c19", 1, 32'h10, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, "t5_c20", 1, 32'h10, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, "t5_c21", 1, 32'h10, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t5_c22", 1, 32'h10, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t5_c23", 1, 32'h14, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t5_c24", 1, 32'h18, 1, 32'h10, 32'h110, 0);

    // 6: PC wrap, then asynchronous reset mid-stream
    step(1, 1, 0, 1, 32'hFFFF_FFFF, "t6_c25", 0, 32'h1C, 1, 32'h14, 32'h114, 0);
    step(1, 1, 0, 0, 0, "t6_c26", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t6_c27", 1, 32'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t6_c28", 1, 32'h4, 1, 32'hFFFF_FFFC, 32'h0000_00FC, 0);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    chk("t6_async.addr", imem_addr, 32'h0);
    @(negedge system_clock);
    @(negedge system_clock);
    reset = 1'b1;
    #1;
    chk("t6_release_req", 32'(imem_req_valid), 32'd0);
    step(1, 1, 0, 0, 0, "t6_r1", 1, 32'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t6_r2", 1, 32'h4, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, "t6_r3", 1, 32'h8, 1, 32'h0, 32'h100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller that owns the program counter and sequences instruction-memory reads for the IF stage. It issues one read per accepted request with fixed 1-cycle read latency, buffers returned instructions in a 2-entry PC-tagged FIFO, and hands them to decode over a valid/ready handshake. It also handles branch/jump redirects (flush plus in-flight kill) and a halt/drain mode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, output buffer entries; fixed at 2, so the credit logic below assumes 2.

Ports:
system_clock  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
imem_req_valid  output  1  read request to instruction memory.
imem_req_ready  input  1  memory accepts the request this cycle; it may be low while memory is shared with a loader.
imem_addr  output  32  word-aligned read address; equals the internal pc.
imem_rdata  input  32  read data, valid exactly 1 cycle after an accepted request.
redirect_valid  input  1  branch/jump taken; single-cycle pulse.
redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.
halt  input  1  level signal; stop issuing new fetches.
fetch_valid  output  1  FIFO head holds a valid instruction.
fetch_ready  input  1  decode accepts the head.
fetch_instruction  output  32  instruction at the FIFO head.
fetch_pc  output  32  PC of the FIFO head.
halted  output  1  the block is in HALTED state.

Behaviour:
- Reset (async, low): pc=RESET_PC, FIFO count=0, inflight=0, kill=0, state=RUN. Outputs after reset: imem_req_valid=0 until the first clock edge after release, fetch_valid=0, fetch_instruction=0, fetch_pc=0, halted=0. Reset asserted mid-operation discards all FIFO contents and any in-flight read.
- States are RUN and HALTED.
  - RUN to HALTED: halt=1 and inflight=0.
  - HALTED to RUN: halt=0.
  - A redirect received in HALTED updates pc but the state stays HALTED.
  - halted=1 only in HALTED.
- Handshake events:
  - pop = fetch_valid & fetch_ready.
  - accept = imem_req_valid & imem_req_ready.
- Issue rule: imem_req_valid=1 only when all of the following hold:
  - state=RUN;
  - halt=0;
  - redirect_valid=0;
  - (count + inflight - pop) < 2.
- On accept:
  - inflight<=1, capture tag_pc<=pc;
  - pc<=pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
- imem_addr equals pc at all times.
- Response: the cycle after accept, if kill=0, push {tag_pc, imem_rdata} into the FIFO. If kill=1, discard the data and clear kill. inflight clears unless a new accept occurs in the same cycle.
- Push and pop in the same cycle: count is unchanged. The credit rule guarantees no push into a full FIFO. An overflow is a design bug and must be flagged by an assertion.
- Throughput: with fetch_ready held at 1 and imem_req_ready=1, one instruction per cycle after 2 cycles of startup latency (request in cycle N, fetch_valid in cycle N+2).
- Redirect in cycle N:
  - FIFO flushed (count<=0), and any pop in cycle N is ignored;
  - pc<=redirect_pc & ~3;
  - if inflight=1 or a request was accepted in cycle N-1, kill<=1;
  - no request is issued in cycle N; the first request to the new pc is issued in cycle N+1;
  - fetch_valid=0 in cycle N+1.
- Simultaneous redirect and halt: the redirect still updates pc, and the halt rules apply.
- Back-to-back redirects: the last redirect wins; kill stays 1 until the stale response is dropped.
- fetch_instruction and fetch_pc hold their values while fetch_valid=1 and fetch_ready=0.

Test Plan:
1. Release reset with RESET_PC=0, imem returning mem[addr>>2]=addr+32'h100, fetch_ready=1 -> imem_addr sequence 0,4,8,... each cycle; fetch_pc=0 with instruction 0x100 appears 2 cycles after the first request; then 1 instruction per cycle.
2. Hold fetch_ready=0 -> exactly 2 requests issued (addr 0 and 4), imem_req_valid=0 afterwards, and the head holds pc 0. Then raise fetch_ready -> head 0, then 4, then 8 with no duplicates or gaps.
3. Pulse redirect_valid with redirect_pc=32'h0000_0043 while one read is in flight and the FIFO holds 1 entry -> fetch_valid=0 next cycle; the stale response is dropped; next imem_addr=0x40; the first delivered fetch_pc=0x40.
4. Assert halt during streaming -> issuing stops the same cycle; the in-flight read drains into the FIFO; halted=1 once inflight=0. Redirect to 0x200 while halted, then release halt -> the first request is to 0x200.
5. Hold imem_req_ready=0 for 3 cycles at pc=0x10 -> imem_req_valid stays 1 with imem_addr=0x10 throughout; pc does not advance; no FIFO push occurs.
6. Set pc to 32'hFFFF_FFFC via redirect -> the next requests are 0xFFFF_FFFC then 0x0. Then assert reset mid-stream -> all outputs reach their reset values asynchronously, and the first fetch after release is RESET_PC.
